mem_port_arbiter: RTL and testbench

//  Shares the single accessor port of mem_ctrl_top between N_REQ core-side requesters
//  (port 0 = instruction fetch, port 1 = load/store unit). Uses round-robin arbitration.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_select.sv | 33 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, command issue, wait for completion)
//   mem_op_e    : operation carried by a granted transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Ports:
//   pending : per-requester request bits
//   ptr     : requester index with highest priority this round
//   idx     : first pending requester found searching upward from ptr, with wrap
//   valid   : at least one requester is pending
module rr_select #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Walk the requesters starting at ptr; the first hit latches and later hits are ignored.
  always_comb begin
    int   cand;
    logic hit;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand  = (int'(ptr) + i) % N;
      hit   = !valid && pending[IW'(cand)];
      idx   = hit ? IW'(cand) : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single mem_ctrl accessor port between N_REQ requesters.
// One transaction at a time: IDLE (arbitrate) -> ISSUE (hold command until accepted)
// -> WAIT (until mem_done_i or timeout) -> IDLE.
// Ports:
//   clk, resetn_i                 : clock, synchronous active-low reset
//   req_load_i / req_store_i      : per-requester level requests, held until req_done_o
//   req_addr_i / req_wdata_i      : packed per-requester address / store data
//   req_rdata_o                   : load data, updated in the done cycle of a load
//   req_done_o / req_err_o        : one-hot completion pulse and coincident error pulse
//   mem_addr_o, mem_wdata_o       : registered command toward mem_ctrl
//   mem_load_o, mem_store_o       : registered command strobes, held until mem_ready_i
//   mem_rdata_i, mem_ready_i, mem_done_i : responses from mem_ctrl
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BITSIZE     = 32,
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     resetn_i,
  input  logic [N_REQ-1:0]         req_load_i,
  input  logic [N_REQ-1:0]         req_store_i,
  input  logic [N_REQ*BITSIZE-1:0] req_addr_i,
  input  logic [N_REQ*BITSIZE-1:0] req_wdata_i,
  output logic [BITSIZE-1:0]       req_rdata_o,
  output logic [N_REQ-1:0]         req_done_o,
  output logic [N_REQ-1:0]         req_err_o,
  output logic [BITSIZE-1:0]       mem_addr_o,
  output logic                     mem_load_o,
  output logic                     mem_store_o,
  output logic [BITSIZE-1:0]       mem_wdata_o,
  input  logic [BITSIZE-1:0]       mem_rdata_i,
  input  logic                     mem_ready_i,
  input  logic                     mem_done_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e          state_r;
  logic [IW-1:0]       rr_ptr_r;
  logic [IW-1:0]       winner_r;
  mem_op_e             op_r;
  logic                both_r;
  logic [CW-1:0]       cnt_r;

  logic [N_REQ-1:0]    pending_s;
  logic [IW-1:0]       sel_idx_s;
  logic                sel_valid_s;
  logic [BITSIZE-1:0]  sel_addr_s;
  logic [BITSIZE-1:0]  sel_wdata_s;
  logic                sel_load_s;
  logic                sel_store_s;
  logic [N_REQ-1:0]    done_vec_s;
  logic [IW-1:0]       next_ptr_s;
  logic                timeout_s;

  assign pending_s = req_load_i | req_store_i;

  rr_select #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_select (
    .pending (pending_s),
    .ptr     (rr_ptr_r),
    .idx     (sel_idx_s),
    .valid   (sel_valid_s)
  );

  // Unpack the selected requester's command fields and build the one-hot of the current winner.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    done_vec_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_addr_s    = (sel_idx_s == IW'(k)) ? req_addr_i[k*BITSIZE +: BITSIZE]  : sel_addr_s;
      sel_wdata_s   = (sel_idx_s == IW'(k)) ? req_wdata_i[k*BITSIZE +: BITSIZE] : sel_wdata_s;
      done_vec_s[k] = (winner_r == IW'(k));
    end
  end

  assign sel_load_s  = req_load_i[sel_idx_s];
  assign sel_store_s = req_store_i[sel_idx_s];
  assign next_ptr_s  = (winner_r == IW'(N_REQ - 1)) ? '0 : winner_r + IW'(1);
  // The counter has seen TIMEOUT_CYC-1 idle WAIT cycles, so this is the last one.
  assign timeout_s   = (cnt_r == CW'(TIMEOUT_CYC - 1));

  // Arbiter FSM with command, timeout and completion registers.
  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_r     <= ARB_IDLE;
      rr_ptr_r    <= '0;
      winner_r    <= '0;
      op_r        <= OP_LOAD;
      both_r      <= 1'b0;
      cnt_r       <= '0;
      req_rdata_o <= '0;
      req_done_o  <= '0;
      req_err_o   <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_load_o  <= 1'b0;
      mem_store_o <= 1'b0;
    end else begin
      req_done_o <= '0;
      req_err_o  <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (sel_valid_s) begin
            winner_r    <= sel_idx_s;
            mem_addr_o  <= sel_addr_s;
            mem_wdata_o <= sel_wdata_s;
            // Load and store together is treated as a store and flagged as an error.
            op_r        <= sel_store_s ? OP_STORE : OP_LOAD;
            both_r      <= sel_load_s & sel_store_s;
            mem_store_o <= sel_store_s;
            mem_load_o  <= !sel_store_s;
            state_r     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_ready_i) begin
            mem_load_o  <= 1'b0;
            mem_store_o <= 1'b0;
            cnt_r       <= '0;
            state_r     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_done_i) begin
            req_done_o <= done_vec_s;
            req_err_o  <= both_r ? done_vec_s : '0;
            if (op_r == OP_LOAD) begin
              req_rdata_o <= mem_rdata_i;
            end
            rr_ptr_r <= next_ptr_s;
            state_r  <= ARB_IDLE;
          end else if (timeout_s) begin
            req_done_o <= done_vec_s;
            req_err_o  <= done_vec_s;
            rr_ptr_r   <= next_ptr_s;
            state_r    <= ARB_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (2 requesters, 4-cycle timeout).
module tb_mem_port_arbiter;

  localparam int BS = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    req_load = 2'b00;
  logic [1:0]    req_store = 2'b00;
  logic [63:0]   req_addr = 64'h0;
  logic [63:0]   req_wdata = 64'h0;
  logic [31:0]   req_rdata;
  logic [1:0]    req_done;
  logic [1:0]    req_err;
  logic [31:0]   mem_addr;
  logic          mem_load;
  logic          mem_store;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ready = 1'b0;
  logic          mem_done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  logic [31:0] m_rdata = 32'h0;

  mem_port_arbiter #(
    .BITSIZE     (BS),
    .N_REQ       (2),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .resetn_i    (resetn),
    .req_load_i  (req_load),
    .req_store_i (req_store),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_rdata_o (req_rdata),
    .req_done_o  (req_done),
    .req_err_o   (req_err),
    .mem_addr_o  (mem_addr),
    .mem_load_o  (mem_load),
    .mem_store_o (mem_store),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready),
    .mem_done_i  (mem_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " mem_load"},  mem_load,  1'b0);
    check({tag, " mem_store"}, mem_store, 1'b0);
    check({tag, " mem_addr"},  mem_addr,  32'h0);
    check({tag, " mem_wdata"}, mem_wdata, 32'h0);
    check({tag, " done"},      req_done,  2'b00);
    check({tag, " err"},       req_err,   2'b00);
    check({tag, " rdata"},     req_rdata, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    tick();
    check_quiet(tag);
    resetn  = 1'b1;
    m_ptr   = 0;
    m_rdata = 32'h0;
  endtask

  // Reference model for one transaction: starts in IDLE with requests driven, returns in
  // the done cycle. rdy_dly = ISSUE cycles with ready low; done_dly = WAIT cycle in which
  // mem_done is raised (0 = never).
  task automatic run_txn(input int rdy_dly, input int done_dly, input logic [31:0] rd,
                         input bit spurious, input string tag, output int won);
    int w;
    bit st, both, fin;
    logic [31:0] ea, ew;
    int j;
    w = -1;
    for (int i = 0; i < 2; i++) begin
      int c;
      c = (m_ptr + i) % 2;
      if (w < 0 && (req_load[c] || req_store[c])) w = c;
    end
    if (w < 0) w = 0;
    won  = w;
    st   = req_store[w];
    both = req_load[w] & req_store[w];
    ea   = req_addr[w*32 +: 32];
    ew   = req_wdata[w*32 +: 32];
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k <= rdy_dly; k++) begin
      check({tag, " issue load"},  mem_load,  !st);
      check({tag, " issue store"}, mem_store, st);
      check({tag, " issue addr"},  mem_addr,  ea);
      check({tag, " issue wdata"}, mem_wdata, ew);
      check({tag, " issue done"},  req_done,  2'b00);
      if (k < rdy_dly) begin
        mem_done = spurious && (k == 0);
        tick();
        mem_done = 1'b0;
      end
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    j   = 1;
    fin = 1'b0;
    while (!fin) begin
      check({tag, " wait load"},  mem_load,  1'b0);
      check({tag, " wait store"}, mem_store, 1'b0);
      if (j == done_dly) begin
        mem_done  = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      tick();
      mem_done = 1'b0;
      if (j == done_dly) begin
        fin = 1'b1;
        if (!st) m_rdata = rd;
        check({tag, " err"}, req_err, both ? (64'd1 << w) : 64'd0);
      end else if (j == TO) begin
        fin = 1'b1;
        check({tag, " timeout err"}, req_err, 64'd1 << w);
      end else begin
        check({tag, " early done"}, req_done, 2'b00);
      end
      j++;
    end
    check({tag, " done"},  req_done,  64'd1 << w);
    check({tag, " rdata"}, req_rdata, m_rdata);
    m_ptr = (w + 1) % 2;
  endtask

  initial begin
    int won;
    resetn = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    resetn = 1'b1;

    // 1: single load from p0
    req_addr[31:0] = 32'h4;
    req_load = 2'b01;
    run_txn(0, 2, 32'hDEADBEEF, 1'b0, "t1", won);
    check("t1 winner", won, 0);
    check("t1 rdata const", req_rdata, 32'hDEADBEEF);
    req_load = 2'b00;
    tick();
    check("t1 done one cycle", req_done, 2'b00);
    check("t1 rdata held", req_rdata, 32'hDEADBEEF);

    // 2: p0 load and p1 store together from a fresh pointer
    do_reset("t2 reset");
    req_addr  = {32'h8, 32'h10};
    req_wdata = {32'h12345678, 32'h0};
    req_load  = 2'b01;
    req_store = 2'b10;
    run_txn(0, 1, 32'hA5A5_0001, 1'b0, "t2a", won);
    check("t2 first winner", won, 0);
    req_load = 2'b00;
    run_txn(0, 2, 32'h0, 1'b0, "t2b", won);
    check("t2 second winner", won, 1);
    check("t2 store keeps rdata", req_rdata, 32'hA5A5_0001);
    req_store = 2'b00;

    // 3: both held continuously alternate
    req_load = 2'b11;
    for (int i = 0; i < 6; i++) begin
      run_txn(0, 1 + (i % 3), $urandom, 1'b0, "t3", won);
      check("t3 alternation", won, i % 2);
    end
    req_load = 2'b00;

    // 4: ready held low for 3 cycles in ISSUE
    req_addr[31:0]  = $urandom;
    req_wdata[31:0] = $urandom;
    req_store = 2'b01;
    run_txn(3, 1, 32'h0, 1'b1, "t4", won);
    check("t4 winner", won, 0);
    req_store = 2'b00;

    // 5: timeout, then normal traffic, then done exactly on the timeout cycle
    req_load = 2'b10;
    run_txn(0, 0, $urandom, 1'b0, "t5 timeout", won);
    check("t5 timeout winner", won, 1);
    req_load = 2'b01;
    run_txn(0, 2, $urandom, 1'b0, "t5 normal", won);
    check("t5 normal winner", won, 0);
    req_load = 2'b10;
    run_txn(0, TO, $urandom, 1'b0, "t5 edge", won);
    req_load = 2'b01;
    req_store = 2'b01;
    run_txn(0, 1, $urandom, 1'b0, "t5 both", won);
    req_load = 2'b00;
    req_store = 2'b00;

    // 6: reset during WAIT with pointer at 1, then late done
    req_load = 2'b10;
    tick();
    check("t6 issue", mem_load, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    req_load = 2'b00;
    do_reset("t6 reset");
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("t6 late done", req_done, 2'b00);
    tick();
    check("t6 no done", req_done, 2'b00);
    check("t6 no cmd", mem_load, 1'b0);
    req_load = 2'b11;
    run_txn(0, 1, $urandom, 1'b0, "t6 after", won);
    check("t6 ptr reset", won, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        req_load[r]  = ($urandom % 2) == 0;
        req_store[r] = ($urandom % 3) == 0;
      end
      if ((req_load | req_store) == 2'b00) req_load[$urandom % 2] = 1'b1;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      run_txn($urandom_range(0, 3), $urandom_range(0, 6), $urandom,
              ($urandom % 4) == 0, "rnd", won);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
